scan_digit_ctrl: RTL and testbench

- Sits between the PS/2 byte receiver and the bank of per-digit scan-code-to-seven-segment decoders.
- Parses the incoming scan-code byte stream: drops break sequences (F0 xx) and extended-key sequences (E0 ...).
- Keeps a right-entry scrolling buffer of the last NUM_DIGITS make codes, edited by Backspace and Esc.
- Drives one 7-bit code per decoder; 7'h7F means a blank digit.

---
 rtl/scan_digit_ctrl.sv | 130 +++++++++++++
 tb/tb_scan_digit_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_digit_ctrl.sv
// scan_digit_ctrl: parses a PS/2 scan-code byte stream (dropping break and
// extended sequences) and keeps a right-entry scrolling buffer of the most
// recent make codes for a bank of per-digit seven-segment decoders.
module scan_digit_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter logic [6:0]  BLANK_CODE = 7'h7F,
  parameter logic [7:0]  BS_CODE    = 8'h66,
  parameter logic [7:0]  ESC_CODE   = 8'h76
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              code_in,
  input  logic                    code_valid,
  output logic [7*NUM_DIGITS-1:0] digit_codes,
  output logic [3:0]              char_count,
  output logic                    update,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  localparam logic [3:0] FULL_COUNT = 4'(NUM_DIGITS);

  state_t     state;
  state_t     state_nxt;
  logic       do_push;
  logic       do_bs;
  logic       do_clr;
  logic [6:0] digits [NUM_DIGITS];

  // Parser state register; reset returns to IDLE so the next byte parses fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and action decode; advances only on a byte strobe
  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_bs     = 1'b0;
    do_clr    = 1'b0;
    if (code_valid) begin
      unique case (state)
        IDLE: begin
          if (code_in == 8'hF0) begin
            state_nxt = BRK;
          end else if (code_in == 8'hE0) begin
            state_nxt = EXT;
          end else if (code_in == BS_CODE) begin
            do_bs = 1'b1;
          end else if (code_in == ESC_CODE) begin
            do_clr = 1'b1;
          end else if (!code_in[7]) begin
            do_push = 1'b1;
          end
        end
        BRK: begin
          state_nxt = IDLE;
        end
        EXT: begin
          state_nxt = (code_in == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Digit buffer, character count and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        digits[i] <= BLANK_CODE;
      end
      char_count <= '0;
      update     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      update   <= 1'b0;
      overflow <= 1'b0;
      if (do_push) begin
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
          digits[i] <= digits[i-1];
        end
        digits[0] <= code_in[6:0];
        if (char_count < FULL_COUNT) begin
          char_count <= char_count + 4'd1;
        end else begin
          overflow <= 1'b1;
        end
        update <= 1'b1;
      end else if (do_bs && (char_count != '0)) begin
        for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
          digits[i] <= digits[i+1];
        end
        digits[NUM_DIGITS-1] <= BLANK_CODE;
        char_count <= char_count - 4'd1;
        update     <= 1'b1;
      end else if (do_clr) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          digits[i] <= BLANK_CODE;
        end
        char_count <= '0;
        update     <= 1'b1;
      end
    end
  end

  // Flatten the buffer; digit 0 occupies the least significant bits
  always_comb begin
    digit_codes = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digit_codes[7*i +: 7] = digits[i];
    end
  end

endmodule

// File: tb/tb_scan_digit_ctrl.sv
// tb_scan_digit_ctrl: directed and randomized byte streams for scan_digit_ctrl,
// compared against a queue-based model of the parser and scrolling buffer.
module tb_scan_digit_ctrl;

  localparam int ND = 6;

  logic          clk;
  logic          reset;
  logic [7:0]    code_in;
  logic          code_valid;
  logic [7*ND-1:0] digit_codes;
  logic [3:0]    char_count;
  logic          update;
  logic          overflow;

  int checks;
  int errors;

  // Model: index 0 of the queue is the newest character
  byte unsigned mq[$];
  bit           m_skip;   // next byte is the tail of a break sequence
  bit           m_ext;    // previous byte was E0
  bit           m_upd;
  bit           m_ovf;

  scan_digit_ctrl #(
    .NUM_DIGITS(ND),
    .BLANK_CODE(7'h7F),
    .BS_CODE(8'h66),
    .ESC_CODE(8'h76)
  ) dut (
    .clk(clk),
    .reset(reset),
    .code_in(code_in),
    .code_valid(code_valid),
    .digit_codes(digit_codes),
    .char_count(char_count),
    .update(update),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model_digits();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) begin
      v[7*i +: 7] = (i < mq.size()) ? 7'(mq[i]) : 7'h7F;
    end
    return v;
  endfunction

  function automatic void model_byte(input byte unsigned b);
    m_upd = 1'b0;
    m_ovf = 1'b0;
    if (m_skip) begin
      m_skip = 1'b0;
    end else if (m_ext) begin
      m_ext = 1'b0;
      if (b == 8'hF0) m_skip = 1'b1;
    end else if (b == 8'hF0) begin
      m_skip = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'h66) begin
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        m_upd = 1'b1;
      end
    end else if (b == 8'h76) begin
      mq.delete();
      m_upd = 1'b1;
    end else if (b < 8'h80) begin
      mq.push_front(b);
      if (mq.size() > ND) begin
        void'(mq.pop_back());
        m_ovf = 1'b1;
      end
      m_upd = 1'b1;
    end
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".digits"}, 64'(digit_codes), model_digits());
    check({tag, ".count"}, 64'(char_count), 64'(mq.size()));
    check({tag, ".update"}, 64'(update), 64'(m_upd));
    check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic do_reset(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    reset      = 1'b1;
    code_valid = with_byte;
    code_in    = b;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    code_valid = 1'b0;
    mq.delete();
    m_skip = 1'b0;
    m_ext  = 1'b0;
    m_upd  = 1'b0;
    m_ovf  = 1'b0;
    check_state("reset");
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_in    = b;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    model_byte(b);
    check_state("byte");
    @(posedge clk);
    #1;
    check("gap.update", 64'(update), 64'd0);
    check("gap.overflow", 64'(overflow), 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    int sel;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    code_in    = '0;
    code_valid = 1'b0;
    m_skip     = 1'b0;
    m_ext      = 1'b0;

    do_reset(1'b0, 8'h00);

    // Make/break pairs
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h32); send(8'hF0); send(8'h32);
    exp = {22'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h1C, 7'h32};
    check("plan1.digits", 64'(digit_codes), exp);
    check("plan1.count", 64'(char_count), 64'd2);

    // Backspace down to empty, then backspace on empty
    send(8'h66);
    check("plan3.bs1", 64'(digit_codes[6:0]), 64'h1C);
    send(8'h66);
    send(8'h66);
    check("plan3.empty", 64'(char_count), 64'd0);

    // Overflow on the seventh push
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    send(8'h2E); send(8'h36); send(8'h3D);
    exp = {22'h0, 7'h1E, 7'h26, 7'h25, 7'h2E, 7'h36, 7'h3D};
    check("plan2.digits", 64'(digit_codes), exp);
    check("plan2.count", 64'(char_count), 64'd6);

    // Extended sequences dropped, high-bit bytes ignored
    send(8'h76);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h24);
    check("plan4.count", 64'(char_count), 64'd1);
    send(8'hAA); send(8'hFA);

    // Clear, then break of Esc ignored
    send(8'h1C); send(8'h32);
    send(8'h76);
    send(8'hF0); send(8'h76);
    check("plan5.count", 64'(char_count), 64'd0);

    // Reset during BRK, coincident with a byte strobe
    send(8'hF0);
    do_reset(1'b1, 8'h1C);
    send(8'h1C);
    check("plan6.count", 64'(char_count), 64'd1);

    // Randomized stream with occasional resets
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 11);
      if ($urandom_range(0, 49) == 0) begin
        do_reset($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      end else begin
        case (sel)
          0:       send(8'hF0);
          1:       send(8'hE0);
          2, 3:    send(8'h66);
          4:       send(8'h76);
          5:       send({1'b1, 7'($urandom_range(0, 127))});
          6:       send(8'h7F);
          default: send({1'b0, 7'($urandom_range(0, 127))});
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
